// File: rtl/heater_multi.sv
// Multi-channel hysteresis heater controller: one regulation FSM per channel
// with latched timeout, over-temperature and sensor-watchdog faults.
module heater_multi #(
  parameter int N_CH    = 4,
  parameter int TEMP_W  = 12,
  parameter int HYST    = 8,
  parameter int OVER    = 64,
  parameter int TIMEOUT = 4096,
  parameter int WDOG    = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   err_clear,
  input  logic [N_CH-1:0]        en,
  input  logic [N_CH*TEMP_W-1:0] setpoint,
  input  logic [N_CH*TEMP_W-1:0] temp,
  input  logic [N_CH-1:0]        temp_valid,
  output logic [N_CH-1:0]        heat_on,
  output logic [N_CH-1:0]        err_ch,
  output logic [2*N_CH-1:0]      fault_cause,
  output logic                   error
);

  localparam int HC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int WD_W = (WDOG > 2) ? $clog2(WDOG) : 1;

  localparam logic [TEMP_W:0] HYST_V = (TEMP_W+1)'(HYST);
  localparam logic [TEMP_W:0] OVER_V = (TEMP_W+1)'(OVER);

  localparam logic [1:0] C_NONE    = 2'b00;
  localparam logic [1:0] C_TIMEOUT = 2'b01;
  localparam logic [1:0] C_OVER    = 2'b10;
  localparam logic [1:0] C_SENSOR  = 2'b11;

  typedef enum logic [1:0] {IDLE, HEAT, HOLD, FAULT} state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e            state_q, state_d;
    logic [1:0]        cause_q, cause_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [TEMP_W:0]   sp, tp, lo, hi;
    logic              valid, over, below_lo, at_sp, to_exp, wd_exp, active_q, active_d;

    // One extra bit keeps lo/hi free of wrap-around at the ends of the code range.
    assign sp       = {1'b0, setpoint[i*TEMP_W +: TEMP_W]};
    assign tp       = {1'b0, temp[i*TEMP_W +: TEMP_W]};
    assign lo       = (sp >= HYST_V) ? sp - HYST_V : '0;
    assign hi       = sp + OVER_V;
    assign valid    = temp_valid[i];
    assign over     = tp > hi;
    assign below_lo = tp < lo;
    assign at_sp    = tp >= sp;
    assign to_exp   = hcnt_q == HC_W'(TIMEOUT - 1);
    assign wd_exp   = wdog_q == WD_W'(WDOG - 1);
    assign active_q = (state_q == HEAT) || (state_q == HOLD);
    assign active_d = (state_d == HEAT) || (state_d == HOLD);

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
        IDLE: begin
          if (en[i] && valid) begin
            if (over) begin
              state_d = FAULT;
              cause_d = C_OVER;
            end else if (below_lo) begin
              state_d = HEAT;
            end else begin
              state_d = HOLD;
            end
          end
        end
        HEAT, HOLD: begin
          if (!en[i]) begin
            state_d = IDLE;
          end else if (valid && over) begin
            state_d = FAULT;
            cause_d = C_OVER;
          end else if (!valid && wd_exp) begin
            state_d = FAULT;
            cause_d = C_SENSOR;
          end else if (state_q == HEAT && valid && at_sp) begin
            state_d = HOLD;
          end else if (state_q == HEAT && to_exp) begin
            state_d = FAULT;
            cause_d = C_TIMEOUT;
          end else if (state_q == HOLD && valid && below_lo) begin
            state_d = HEAT;
          end
        end
        FAULT: begin
          if (err_clear) begin
            state_d = IDLE;
            cause_d = C_NONE;
          end
        end
        default: begin
          state_d = IDLE;
          cause_d = C_NONE;
        end
      endcase
    end

    // Both counters restart whenever the channel enters or leaves the counted state.
    assign hcnt_d = (state_q == HEAT && state_d == HEAT) ? hcnt_q + 1'b1 : '0;
    assign wdog_d = (active_q && active_d && !valid) ? wdog_q + 1'b1 : '0;

    // NOTE: sequential state uses non-blocking assignments so all channels update from pre-edge values.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        cause_q <= C_NONE;
        hcnt_q  <= '0;
        wdog_q  <= '0;
      end else begin
        state_q <= state_d;
        cause_q <= cause_d;
        hcnt_q  <= hcnt_d;
        wdog_q  <= wdog_d;
      end
    end

    assign heat_on[i]           = state_q == HEAT;
    assign err_ch[i]            = state_q == FAULT;
    assign fault_cause[2*i +: 2] = cause_q;
  end

  assign error = |err_ch;

endmodule

// File: tb/tb_heater_multi.sv
// Directed self-checking bench for heater_multi with default parameters.
module tb_heater_multi;

  localparam int N_CH = 4;
  localparam int TW   = 12;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 err_clear;
  logic [N_CH-1:0]      en;
  logic [N_CH*TW-1:0]   setpoint;
  logic [N_CH*TW-1:0]   temp;
  logic [N_CH-1:0]      temp_valid;
  logic [N_CH-1:0]      heat_on;
  logic [N_CH-1:0]      err_ch;
  logic [2*N_CH-1:0]    fault_cause;
  logic                 error;

  int total = 0;
  int bad   = 0;

  heater_multi dut (
    .clk         (clk),
    .reset       (reset),
    .err_clear   (err_clear),
    .en          (en),
    .setpoint    (setpoint),
    .temp        (temp),
    .temp_valid  (temp_valid),
    .heat_on     (heat_on),
    .err_ch      (err_ch),
    .fault_cause (fault_cause),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic e, input logic [TW-1:0] sp,
                        input logic [TW-1:0] t, input logic v);
    en[i]                  = e;
    setpoint[i*TW +: TW]   = sp;
    temp[i*TW +: TW]       = t;
    temp_valid[i]          = v;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({heat_on, err_ch, fault_cause, error} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs: got heat=%b err=%b cause=%b error=%b want all 0",
               heat_on, err_ch, fault_cause, error);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_regulate();
    set_ch(0, 1'b1, 12'd1000, 12'd900, 1'b1);
    tick();
    total++;
    if (heat_on[0] !== 1'b1) begin bad++; $display("FAIL reg_start: heat_on0=%b want 1", heat_on[0]); end
    set_ch(0, 1'b1, 12'd1000, 12'd1000, 1'b1);
    tick();
    total++;
    if (heat_on[0] !== 1'b0) begin bad++; $display("FAIL reg_reach_sp: heat_on0=%b want 0", heat_on[0]); end
    set_ch(0, 1'b1, 12'd1000, 12'd995, 1'b1);
    tick();
    total++;
    if (heat_on[0] !== 1'b0) begin bad++; $display("FAIL reg_in_band: heat_on0=%b want 0", heat_on[0]); end
    set_ch(0, 1'b1, 12'd1000, 12'd991, 1'b1);
    tick();
    total++;
    if (heat_on[0] !== 1'b1) begin bad++; $display("FAIL reg_below_lo: heat_on0=%b want 1", heat_on[0]); end
    set_ch(0, 1'b0, 12'd1000, 12'd991, 1'b0);
    tick();
    total++;
    if (heat_on[0] !== 1'b0) begin bad++; $display("FAIL reg_disable: heat_on0=%b want 0", heat_on[0]); end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    int cyc;
    set_ch(1, 1'b1, 12'd1000, 12'd500, 1'b1);
    tick();
    cyc = 1;
    while (heat_on[1] === 1'b1 && cnt < 5000) begin
      cnt++;
      tick();
      cyc++;
    end
    total++;
    if (cnt !== 4096) begin bad++; $display("FAIL timeout_len: heat cycles=%0d want 4096", cnt); end
    total++;
    if (err_ch[1] !== 1'b1 || error !== 1'b1 || fault_cause !== 8'b00_00_01_00) begin
      bad++;
      $display("FAIL timeout_fault: err=%b error=%b cause=%b want err1=1 error=1 cause=00000100",
               err_ch, error, fault_cause);
    end
    while (cyc < 4600) begin
      tick();
      cyc++;
    end
    total++;
    if (err_ch[1] !== 1'b1 || heat_on[1] !== 1'b0) begin
      bad++; $display("FAIL timeout_held: err1=%b heat1=%b want 1 0", err_ch[1], heat_on[1]);
    end
    pulse_clear();
    total++;
    if (error !== 1'b0 || err_ch[1] !== 1'b0 || heat_on[1] !== 1'b0 || fault_cause !== 8'd0) begin
      bad++;
      $display("FAIL timeout_clear: error=%b err1=%b heat1=%b cause=%b want 0 0 0 0",
               error, err_ch[1], heat_on[1], fault_cause);
    end
    tick();
    total++;
    if (heat_on[1] !== 1'b1) begin bad++; $display("FAIL timeout_resume: heat1=%b want 1", heat_on[1]); end
    set_ch(1, 1'b0, 12'd1000, 12'd500, 1'b0);
    tick();
  endtask

  task automatic test_overtemp();
    set_ch(2, 1'b1, 12'd1000, 12'd1065, 1'b1);
    tick();
    total++;
    if (err_ch[2] !== 1'b1 || fault_cause[5:4] !== 2'b10 || heat_on[2] !== 1'b0) begin
      bad++;
      $display("FAIL over_fault: err2=%b cause2=%b heat2=%b want 1 10 0",
               err_ch[2], fault_cause[5:4], heat_on[2]);
    end
    set_ch(2, 1'b1, 12'd1000, 12'd1064, 1'b1);
    pulse_clear();
    total++;
    if (err_ch[2] !== 1'b0 || fault_cause[5:4] !== 2'b00) begin
      bad++; $display("FAIL over_clear: err2=%b cause2=%b want 0 00", err_ch[2], fault_cause[5:4]);
    end
    tick();
    tick();
    total++;
    if (err_ch[2] !== 1'b0 || heat_on[2] !== 1'b0) begin
      bad++; $display("FAIL over_edge_hold: err2=%b heat2=%b want 0 0", err_ch[2], heat_on[2]);
    end
  endtask

  task automatic test_watchdog();
    int n = 0;
    set_ch(0, 1'b1, 12'd1000, 12'd900, 1'b1);
    set_ch(1, 1'b1, 12'd1000, 12'd1000, 1'b1);
    set_ch(2, 1'b1, 12'd1000, 12'd1010, 1'b1);
    set_ch(3, 1'b1, 12'd1000, 12'd1000, 1'b1);
    tick();
    temp_valid[3] = 1'b0;
    while (err_ch[3] !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (n !== 256) begin bad++; $display("FAIL wdog_latency: cycles=%0d want 256", n); end
    total++;
    if (fault_cause !== 8'b11_00_00_00 || error !== 1'b1) begin
      bad++; $display("FAIL wdog_cause: cause=%b error=%b want 11000000 1", fault_cause, error);
    end
    total++;
    if (heat_on !== 4'b0001 || err_ch !== 4'b1000) begin
      bad++; $display("FAIL wdog_isolation: heat=%b err=%b want 0001 1000", heat_on, err_ch);
    end
    en = '0;
    temp_valid = '0;
    pulse_clear();
    tick();
  endtask

  task automatic test_boundary();
    // setpoint below hysteresis: lo clamps to 0 and the channel never heats
    set_ch(0, 1'b1, 12'd4, 12'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (heat_on[0] !== 1'b0) begin bad++; $display("FAIL clamp_lo[%0d]: heat0=%b want 0", k, heat_on[0]); end
    end
    set_ch(0, 1'b0, 12'd4, 12'd0, 1'b0);

    // err_clear coinciding with the timeout edge
    set_ch(1, 1'b1, 12'd1000, 12'd500, 1'b1);
    tick();
    for (int k = 0; k < 4095; k++) tick();
    total++;
    if (heat_on[1] !== 1'b1) begin bad++; $display("FAIL clr_to_pre: heat1=%b want 1", heat_on[1]); end
    pulse_clear();
    total++;
    if (err_ch[1] !== 1'b1 || fault_cause[3:2] !== 2'b01 || heat_on[1] !== 1'b0) begin
      bad++;
      $display("FAIL clr_to_latch: err1=%b cause1=%b heat1=%b want 1 01 0",
               err_ch[1], fault_cause[3:2], heat_on[1]);
    end
    set_ch(1, 1'b0, 12'd1000, 12'd500, 1'b0);
    pulse_clear();

    // en dropped on the same edge as an over-temp sample
    set_ch(2, 1'b1, 12'd1000, 12'd900, 1'b1);
    tick();
    total++;
    if (heat_on[2] !== 1'b1) begin bad++; $display("FAIL endrop_pre: heat2=%b want 1", heat_on[2]); end
    set_ch(2, 1'b0, 12'd1000, 12'd2000, 1'b1);
    tick();
    total++;
    if (heat_on[2] !== 1'b0 || err_ch[2] !== 1'b0 || fault_cause[5:4] !== 2'b00) begin
      bad++;
      $display("FAIL endrop_overtemp: heat2=%b err2=%b cause2=%b want 0 0 00",
               heat_on[2], err_ch[2], fault_cause[5:4]);
    end
    set_ch(2, 1'b0, 12'd1000, 12'd900, 1'b0);

    // reset while one channel heats and another sits in FAULT
    set_ch(0, 1'b1, 12'd1000, 12'd900, 1'b1);
    set_ch(3, 1'b1, 12'd1000, 12'd2000, 1'b1);
    tick();
    total++;
    if (heat_on[0] !== 1'b1 || err_ch[3] !== 1'b1) begin
      bad++; $display("FAIL rst_pre: heat0=%b err3=%b want 1 1", heat_on[0], err_ch[3]);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({heat_on, err_ch, fault_cause, error} !== 17'd0) begin
      bad++;
      $display("FAIL rst_mid_heat: heat=%b err=%b cause=%b error=%b want all 0",
               heat_on, err_ch, fault_cause, error);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    err_clear  = 1'b0;
    en         = '0;
    setpoint   = '0;
    temp       = '0;
    temp_valid = '0;
    test_reset();
    test_regulate();
    test_timeout();
    test_overtemp();
    test_watchdog();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
